// File: rtl/instr_word_loader_pkg.sv
// Shared debug-unit definitions for the instruction word loader:
// loader states, word geometry and the end-of-program marker.
package instr_word_loader_pkg;

    localparam int BYTE_WIDTH         = 8;
    localparam int BYTES_PER_WORD     = 4;
    localparam int INSTRUCT_MEM_WIDTH = BYTES_PER_WORD * BYTE_WIDTH;
    localparam int ADDR_WIDTH         = 8;
    localparam int BYTE_CNT_W         = $clog2(BYTES_PER_WORD);

    localparam logic [INSTRUCT_MEM_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/instr_word_loader_if.sv
// Byte input, session control and instruction-memory write port of the loader.
// The loader itself connects through the slave modport.
interface instr_word_loader_if;
    import instr_word_loader_pkg::*;

    logic                          i_load_start;
    logic                          i_rx_done;
    logic [BYTE_WIDTH-1:0]         i_rx_data;
    logic                          o_mem_wr_en;
    logic [ADDR_WIDTH-1:0]         o_mem_addr;
    logic [INSTRUCT_MEM_WIDTH-1:0] o_mem_data;
    logic                          o_load_busy;
    logic                          o_load_done;
    logic                          o_overflow;

    modport master (
        output i_load_start, i_rx_done, i_rx_data,
        input  o_mem_wr_en, o_mem_addr, o_mem_data,
        input  o_load_busy, o_load_done, o_overflow
    );

    modport slave (
        input  i_load_start, i_rx_done, i_rx_data,
        output o_mem_wr_en, o_mem_addr, o_mem_data,
        output o_load_busy, o_load_done, o_overflow
    );

endinterface

// File: rtl/instr_word_loader_byte_word_packer.sv
// Little-endian byte-to-word packer: collects BYTES_PER_WORD bytes and strobes
// o_word_valid together with the completed word on the last byte.
module instr_word_loader_byte_word_packer
    import instr_word_loader_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_clear,
    input  logic                          i_byte_valid,
    input  logic [BYTE_WIDTH-1:0]         i_byte_data,
    output logic                          o_word_valid,
    output logic [INSTRUCT_MEM_WIDTH-1:0] o_word
);

    localparam logic [BYTE_CNT_W-1:0] LAST_CNT = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [BYTE_CNT_W-1:0]         r_count;
    logic [INSTRUCT_MEM_WIDTH-1:0] r_assembly;
    logic [INSTRUCT_MEM_WIDTH-1:0] w_word;
    logic                          w_last;

    always_comb begin
        w_word = r_assembly;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (r_count == BYTE_CNT_W'(k)) begin
                w_word[k*BYTE_WIDTH +: BYTE_WIDTH] = i_byte_data;
            end
        end
    end

    assign w_last       = (r_count == LAST_CNT);
    assign o_word_valid = i_byte_valid && w_last && !i_clear;
    assign o_word       = w_word;

    // A clear wins over a byte arriving in the same cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_count    <= '0;
            r_assembly <= '0;
        end else if (i_clear) begin
            r_count    <= '0;
            r_assembly <= '0;
        end else if (i_byte_valid) begin
            if (w_last) begin
                r_count    <= '0;
                r_assembly <= '0;
            end else begin
                r_count    <= r_count + 1'b1;
                r_assembly <= w_word;
            end
        end
    end

endmodule

// File: rtl/instr_word_loader.sv
// Instruction word loader: packs UART bytes into words and writes them to
// instruction memory at an auto-incrementing address until halt or full.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, no session yet; bytes ignored
// ST_RECV  | session active, collecting bytes of the next word
// ST_WRITE | one-cycle memory write of the completed word
// ST_DONE  | halt written or memory full; bytes ignored until restart
module instr_word_loader
    import instr_word_loader_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    instr_word_loader_if.slave   bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    loader_state_e                 r_state;
    logic                          r_mem_wr_en;
    logic [ADDR_WIDTH-1:0]         r_addr;
    logic [INSTRUCT_MEM_WIDTH-1:0] r_mem_data;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_overflow;

    logic                          w_is_halt;
    logic                          w_at_top;
    logic                          w_write_ends;
    logic                          w_byte_accept;
    logic                          w_word_valid;
    logic [INSTRUCT_MEM_WIDTH-1:0] w_word;

    assign w_is_halt    = (r_mem_data == HALT_WORD);
    assign w_at_top     = (r_addr == ADDR_MAX);
    assign w_write_ends = w_is_halt || w_at_top;

    // A byte landing in the write cycle belongs to the next word only if the session continues.
    assign w_byte_accept = bus.i_rx_done &&
                           ((r_state == ST_RECV) || ((r_state == ST_WRITE) && !w_write_ends));

    instr_word_loader_byte_word_packer u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (bus.i_load_start),
        .i_byte_valid (w_byte_accept),
        .i_byte_data  (bus.i_rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_mem_wr_en <= 1'b0;
            r_addr      <= '0;
            r_mem_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_mem_wr_en <= 1'b0;
            if (bus.i_load_start) begin
                r_state    <= ST_RECV;
                r_addr     <= '0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    ST_RECV: begin
                        if (w_word_valid) begin
                            r_mem_data  <= w_word;
                            r_mem_wr_en <= 1'b1;
                            r_state     <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        if (w_is_halt) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_at_top) begin
                            r_state    <= ST_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_overflow <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= ST_RECV;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.o_mem_wr_en = r_mem_wr_en;
    assign bus.o_mem_addr  = r_addr;
    assign bus.o_mem_data  = r_mem_data;
    assign bus.o_load_busy = r_busy;
    assign bus.o_load_done = r_done;
    assign bus.o_overflow  = r_overflow;

endmodule

// File: tb/tb_instr_word_loader.sv
// Directed bench for instr_word_loader: table of single-word sessions plus
// hand-written sequences for halt, overflow, restart, reset and write-cycle bytes.
module tb_instr_word_loader;

    logic clk;
    logic rst_n;

    instr_word_loader_if bus ();

    instr_word_loader dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];

    always @(negedge clk) begin
        if (bus.o_mem_wr_en === 1'b1) begin
            q_addr.push_back(bus.o_mem_addr);
            q_data.push_back(bus.o_mem_data);
        end
    end

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wr(input string name, input int idx, input logic [7:0] ea, input logic [31:0] ed);
        if (idx < q_addr.size()) begin
            check({name, "_addr"}, 32'(q_addr[idx]), 32'(ea));
            check({name, "_data"}, q_data[idx], ed);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: write %0d missing (only %0d writes) expected addr %0h data %0h",
                     name, idx, q_addr.size(), ea, ed);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.i_rx_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        strobe(b);
        idle(1);
    endtask

    task automatic do_start();
        bus.i_load_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_load_start = 1'b0;
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 32'(bus.o_mem_wr_en), 32'd0);
        check({tag, "_addr"},  32'(bus.o_mem_addr),  32'd0);
        check({tag, "_data"},  bus.o_mem_data,       32'd0);
        check({tag, "_busy"},  32'(bus.o_load_busy), 32'd0);
        check({tag, "_done"},  32'(bus.o_load_done), 32'd0);
        check({tag, "_ovf"},   32'(bus.o_overflow),  32'd0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h1234_5678, 1'b1, 1'b0};
        vecs[1] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCC_BBAA, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 32'h7FFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 1'b0, 1'b1};

        rst_n            = 1'b0;
        bus.i_load_start = 1'b0;
        bus.i_rx_done    = 1'b0;
        bus.i_rx_data    = 8'h00;
        #3;
        check_all_zero("reset");
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Bytes before any start are ignored.
        clear_q();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("idle_writes", 32'(q_addr.size()), 32'd0);
        check("idle_busy", 32'(bus.o_load_busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_start();
            check("start_busy", 32'(bus.o_load_busy), 32'd1);
            clear_q();
            send_byte(vecs[i].b0);
            send_byte(vecs[i].b1);
            send_byte(vecs[i].b2);
            send_byte(vecs[i].b3);
            idle(1);
            check("vec_nwrites", 32'(q_addr.size()), 32'd1);
            check_wr("vec_wr", 0, 8'h00, vecs[i].exp_data);
            check("vec_busy", 32'(bus.o_load_busy), 32'(vecs[i].exp_busy));
            check("vec_done", 32'(bus.o_load_done), 32'(vecs[i].exp_done));
            check("vec_ovf",  32'(bus.o_overflow),  32'd0);
        end

        // Two words then halt, with exact write/done timing.
        do_start();
        clear_q();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        strobe(8'hFF);
        check("halt_wr_en", 32'(bus.o_mem_wr_en), 32'd1);
        check("halt_addr",  32'(bus.o_mem_addr),  32'd2);
        check("halt_data",  bus.o_mem_data,       32'hFFFF_FFFF);
        check("halt_done_early", 32'(bus.o_load_done), 32'd0);
        idle(1);
        check("halt_done", 32'(bus.o_load_done), 32'd1);
        check("halt_busy", 32'(bus.o_load_busy), 32'd0);
        check("halt_wr_off", 32'(bus.o_mem_wr_en), 32'd0);
        check("halt_addr_hold", 32'(bus.o_mem_addr), 32'd2);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("halt_nwrites", 32'(q_addr.size()), 32'd3);
        check_wr("halt_w0", 0, 8'h00, 32'h0403_0201);
        check_wr("halt_w1", 1, 8'h01, 32'h0807_0605);
        check_wr("halt_w2", 2, 8'h02, 32'hFFFF_FFFF);

        // Fill all 256 words without a halt.
        do_start();
        clear_q();
        for (int w = 0; w < 256; w++) begin
            send_byte(8'(w)); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end
        idle(1);
        check("ovf_nwrites", 32'(q_addr.size()), 32'd256);
        bad = 0;
        for (int w = 0; w < 256 && w < q_addr.size(); w++) begin
            if (q_addr[w] !== 8'(w) || q_data[w] !== 32'(w)) bad++;
        end
        check("ovf_seq_errors", 32'(bad), 32'd0);
        check_wr("ovf_last", 255, 8'hFF, 32'h0000_00FF);
        check("ovf_done", 32'(bus.o_load_done), 32'd1);
        check("ovf_flag", 32'(bus.o_overflow),  32'd1);
        check("ovf_busy", 32'(bus.o_load_busy), 32'd0);
        check("ovf_addr_hold", 32'(bus.o_mem_addr), 32'hFF);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("ovf_no_more", 32'(q_addr.size()), 32'd256);

        // Restart clears sticky flags and drops a partial word.
        do_start();
        check("rs_done_clr", 32'(bus.o_load_done), 32'd0);
        check("rs_ovf_clr",  32'(bus.o_overflow),  32'd0);
        check("rs_addr_clr", 32'(bus.o_mem_addr),  32'd0);
        clear_q();
        send_byte(8'hAA); send_byte(8'hBB);
        do_start();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(1);
        check("rs_nwrites", 32'(q_addr.size()), 32'd1);
        check_wr("rs_wr", 0, 8'h00, 32'hDDCC_BBAA);

        // Start wins over a simultaneous byte strobe.
        clear_q();
        bus.i_load_start = 1'b1;
        strobe(8'h55);
        bus.i_load_start = 1'b0;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("sim_nwrites", 32'(q_addr.size()), 32'd1);
        check_wr("sim_wr", 0, 8'h00, 32'h0403_0201);

        // Reset in the middle of a word.
        do_start();
        clear_q();
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h40); send_byte(8'h50); send_byte(8'h60); send_byte(8'h70);
        check("mid_rst_nwrites", 32'(q_addr.size()), 32'd0);
        do_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("post_rst_nwrites", 32'(q_addr.size()), 32'd1);
        check_wr("post_rst_wr", 0, 8'h00, 32'h4433_2211);

        // Bytes arriving in the WRITE cycle.
        do_start();
        clear_q();
        strobe(8'h01); strobe(8'h02); strobe(8'h03); strobe(8'h04); strobe(8'h05);
        send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        strobe(8'hFF); strobe(8'hFF); strobe(8'hFF); strobe(8'hFF); strobe(8'h5A);
        idle(2);
        check("wc_nwrites", 32'(q_addr.size()), 32'd3);
        check_wr("wc_w0", 0, 8'h00, 32'h0403_0201);
        check_wr("wc_w1", 1, 8'h01, 32'h0807_0605);
        check_wr("wc_w2", 2, 8'h02, 32'hFFFF_FFFF);
        check("wc_done", 32'(bus.o_load_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
